// File: rtl/ccm_port_arbiter.sv
// Single-port CCM arbiter between instruction fetch (IF) and load/store (LS).
// LS wins by default; IF gets forced priority after STARVE_MAX consecutive denials.
module ccm_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,

  input  logic        ls_req_valid,
  input  logic        ls_req_we,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    TagNone = 2'd0,
    TagIf   = 2'd1,
    TagLs   = 2'd2
  } tag_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  tag_e       tag_q, tag_d;

  logic if_force;
  logic grant_if;
  logic grant_ls;

  // Byte offset bits are dropped on the way to the word-addressed CCM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[1:0], ls_req_addr[1:0]};

  // Grant decode; rst_n gating keeps every handshake output low while in reset.
  always_comb begin
    if_force = (starve_q == StarveMax);
    grant_if = rst_n & if_req_valid & (~ls_req_valid | if_force);
    grant_ls = rst_n & ls_req_valid & ~grant_if;
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // Starvation counter: counts denied IF cycles, saturating at StarveMax.
  always_comb begin
    starve_d = '0;
    if (if_req_valid && !grant_if) begin
      if (starve_q < StarveMax) begin
        starve_d = starve_q + 4'd1;
      end else begin
        starve_d = starve_q;
      end
    end
  end

  // Response tag: only reads produce a response.
  always_comb begin
    tag_d = TagNone;
    if (grant_if) begin
      tag_d = TagIf;
    end else if (grant_ls && !ls_req_we) begin
      tag_d = TagLs;
    end
  end

  // Memory port mux.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_if) begin
      mem_en   = 1'b1;
      mem_addr = {2'b00, if_req_addr[31:2]};
    end else if (grant_ls) begin
      mem_en    = 1'b1;
      mem_we    = ls_req_we;
      mem_addr  = {2'b00, ls_req_addr[31:2]};
      mem_wdata = ls_req_wdata;
    end
  end

  // Response outputs, data zeroed when not valid.
  always_comb begin
    if_rsp_valid = (tag_q == TagIf);
    ls_rsp_valid = (tag_q == TagLs);
    if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
    ls_rsp_data  = ls_rsp_valid ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      tag_q    <= TagNone;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(grant_if && grant_ls));

  a_starve_bound: assert property (@(posedge clk) disable iff (!rst_n)
    starve_q <= StarveMax);

  a_rsp_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_rsp_valid && ls_rsp_valid));

  a_no_grant_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(grant_if || grant_ls) |-> (!mem_en && !mem_we && mem_addr == '0 && mem_wdata == '0));

endmodule

// File: tb/tb_ccm_port_arbiter.sv
// Directed bench for ccm_port_arbiter: grant-cycle checks inline, read responses
// checked by an independent monitor against queued expectations.
module tb_ccm_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  ccm_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .ls_req_valid (ls_req_valid),
    .ls_req_we    (ls_req_we),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_data  (ls_rsp_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // CCM model: word i initially holds 0x1000_0000 + i; stores override.
  logic [31:0] store_mem [64];
  logic [63:0] written_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else if (mem_en && mem_we) begin
      store_mem[mem_addr[5:0]] <= mem_wdata;
      written_q[mem_addr[5:0]] <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      mem_rdata <= written_q[mem_addr[5:0]] ? store_mem[mem_addr[5:0]]
                                            : 32'h1000_0000 + {26'd0, mem_addr[5:0]};
    end
  end

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t if_q[$];
  exp_t ls_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    chk("rsp_exclusive", {31'd0, if_rsp_valid & ls_rsp_valid}, 32'd0);
    while (if_q.size() > 0 && if_q[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL if_rsp_missing: got none, expected %h due cycle %0d", if_q[0].data, if_q[0].due);
      void'(if_q.pop_front());
    end
    while (ls_q.size() > 0 && ls_q[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL ls_rsp_missing: got none, expected %h due cycle %0d", ls_q[0].data, ls_q[0].due);
      void'(ls_q.pop_front());
    end
    if (if_rsp_valid) begin
      if (if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_rsp_unexpected: got %h, expected no response (cycle %0d)", if_rsp_data, cyc);
      end else begin
        e = if_q.pop_front();
        chk("if_rsp_data", if_rsp_data, e.data);
        chk("if_rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("if_rsp_data_idle", if_rsp_data, 32'd0);
    end
    if (ls_rsp_valid) begin
      if (ls_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ls_rsp_unexpected: got %h, expected no response (cycle %0d)", ls_rsp_data, cyc);
      end else begin
        e = ls_q.pop_front();
        chk("ls_rsp_data", ls_rsp_data, e.data);
        chk("ls_rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("ls_rsp_data_idle", ls_rsp_data, 32'd0);
    end
  end

  // Drive one cycle of requests (called #1 after a rising edge), check the grant
  // at the falling edge, queue the expected read data, then advance.
  task automatic issue(input string name,
                       input logic ifv, input logic [31:0] ifa,
                       input logic lsv, input logic lswe,
                       input logic [31:0] lsa, input logic [31:0] lswd,
                       input logic exp_if, input logic exp_ls,
                       input logic [31:0] exp_rd);
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    if_req_valid = ifv;
    if_req_addr  = ifa;
    ls_req_valid = lsv;
    ls_req_we    = lswe;
    ls_req_addr  = lsa;
    ls_req_wdata = lswd;
    e_addr  = exp_if ? {2'b00, ifa[31:2]} : (exp_ls ? {2'b00, lsa[31:2]} : 32'd0);
    e_wdata = exp_ls ? lswd : 32'd0;
    e_we    = exp_ls & lswe;
    @(negedge clk);
    chk({name, ".if_ready"}, {31'd0, if_req_ready}, {31'd0, exp_if});
    chk({name, ".ls_ready"}, {31'd0, ls_req_ready}, {31'd0, exp_ls});
    chk({name, ".mem_en"}, {31'd0, mem_en}, {31'd0, exp_if | exp_ls});
    chk({name, ".mem_we"}, {31'd0, mem_we}, {31'd0, e_we});
    chk({name, ".mem_addr"}, mem_addr, e_addr);
    chk({name, ".mem_wdata"}, mem_wdata, e_wdata);
    if (exp_if) if_q.push_back('{data: exp_rd, due: cyc + 1});
    if (exp_ls && !lswe) ls_q.push_back('{data: exp_rd, due: cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk(input string name);
    chk({name, ".if_ready"}, {31'd0, if_req_ready}, 32'd0);
    chk({name, ".ls_ready"}, {31'd0, ls_req_ready}, 32'd0);
    chk({name, ".if_rsp_valid"}, {31'd0, if_rsp_valid}, 32'd0);
    chk({name, ".ls_rsp_valid"}, {31'd0, ls_rsp_valid}, 32'd0);
    chk({name, ".mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({name, ".mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({name, ".mem_addr"}, mem_addr, 32'd0);
    chk({name, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({name, ".if_rsp_data"}, if_rsp_data, 32'd0);
    chk({name, ".ls_rsp_data"}, ls_rsp_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] starve_pat;
    logic [7:0] clr_ifv;
    logic [7:0] clr_pat;

    // Requests asserted during reset must not be granted.
    rst_n        = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0040;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    ls_req_addr  = 32'h0000_0044;
    ls_req_wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_chk("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First grant in the first cycle after release; IF-only read.
    issue("if_read", 1, 32'h0000_0010, 0, 0, 32'h0, 32'h0, 1, 0, 32'h1000_0004);
    issue("ls_store", 0, 32'h0, 1, 1, 32'h0000_0008, 32'hDEAD_BEEF, 0, 1, 32'h0);
    issue("idle0", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    // Back-to-back IF read (misaligned) then LS load of the stored word.
    issue("if_misalign", 1, 32'h0000_0013, 0, 0, 32'h0, 32'h0, 1, 0, 32'h1000_0004);
    issue("ls_load", 0, 32'h0, 1, 0, 32'h0000_000B, 32'h0, 0, 1, 32'hDEAD_BEEF);
    issue("idle1", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Both valid every cycle: LS x4, IF, LS x4, IF.
    starve_pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      issue($sformatf("starve%0d", i), 1, 32'h0000_0020, 1, 0, 32'h0000_0024, 32'h0,
            starve_pat[i], ~starve_pat[i],
            starve_pat[i] ? 32'h1000_0008 : 32'h1000_0009);
    end

    // IF dropping its request clears the count.
    clr_ifv = 8'b11111011;
    clr_pat = 8'b10000000;
    for (int i = 0; i < 8; i++) begin
      issue($sformatf("clear%0d", i), clr_ifv[i], 32'h0000_0020, 1, 0, 32'h0000_0024, 32'h0,
            clr_pat[i], ~clr_pat[i],
            clr_pat[i] ? 32'h1000_0008 : 32'h1000_0009);
    end
    issue("idle2", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Reset lands while a read is in flight: response is dropped.
    issue("inflight", 1, 32'h0000_0010, 0, 0, 32'h0, 32'h0, 1, 0, 32'h1000_0004);
    rst_n = 1'b0;
    if_q.delete();
    ls_q.delete();
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b0;
    @(negedge clk);
    reset_chk("inflight_rst0");
    @(posedge clk);
    @(negedge clk);
    reset_chk("inflight_rst1");
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    rst_n = 1'b1;
    issue("post_rst0", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    issue("post_rst1", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    issue("post_rst_ls", 0, 32'h0, 1, 0, 32'h0000_0004, 32'h0, 0, 1, 32'h1000_0001);
    issue("idle3", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    issue("idle4", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    chk("if_queue_drained", 32'(if_q.size()), 32'd0);
    chk("ls_queue_drained", 32'(ls_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
